fp6_norm_arbiter: RTL and testbench

//  Shares one FP6 (E2M3) addition normalizer among NUM_REQ adder lanes of the MX FP6 compute array.

---
 rtl/fp6_pkg.sv | 21 ++
 rtl/addition_normalizer_fp6.sv | 38 +++
 rtl/fp6_norm_arbiter.sv | 122 ++++++++++++
 tb/tb_fp6_norm_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp6_pkg.sv
// Shared FP6 (E2M3) payload types for the normalizer arbiter.
//   fp6_raw_t  : raw adder sum {sign, e[1:0], m[3:0]}, m[3] is the hidden bit
//   fp6_norm_t : normalized result {sign, e[1:0], m[4:0]}
package fp6_pkg;

  localparam int unsigned FP6_E_W = 2;
  localparam int unsigned FP6_M_W = 3;

  typedef struct packed {
    logic               sign;
    logic [FP6_E_W-1:0] e;
    logic [FP6_M_W:0]   m;
  } fp6_raw_t;

  typedef struct packed {
    logic                 sign;
    logic [FP6_E_W-1:0]   e;
    logic [FP6_M_W+1:0]   m;
  } fp6_norm_t;

endpackage

// File: rtl/addition_normalizer_fp6.sv
// Combinational FP6 addition normalizer (non-zero mantissa path).
//   raw    : raw sum from stage 1
//   norm_c : normalized result; an all-zero mantissa is handled by the caller
module addition_normalizer_fp6
  import fp6_pkg::*;
(
  input  fp6_raw_t  raw,
  output fp6_norm_t norm_c
);

  // Shift left by the leading-zero count, limited by the available exponent range.
  always_comb begin
    norm_c.sign = raw.sign;
    norm_c.e    = raw.e;
    norm_c.m    = {1'b0, raw.m};
    if (raw.m[3]) begin
      norm_c.e = raw.e;
    end else if (raw.m[2]) begin
      // Already at the minimum exponent: leave unnormalized.
      if (raw.e != 2'd0) begin
        norm_c.e = raw.e - 2'd1;
        norm_c.m = {raw.m, 1'b0};
      end
    end else if (raw.m[1]) begin
      // Exponent wraps modulo 4 by design of the lane datapath.
      norm_c.e = raw.e - 2'd2;
      norm_c.m = {raw.m[2:0], 2'b00};
    end else if (raw.m[0]) begin
      norm_c.e = 2'd0;
      if (raw.e == 2'd3) begin
        norm_c.m = 5'b01000;
      end else begin
        norm_c.m = 5'd1 << raw.e;
      end
    end
  end

endmodule

// File: rtl/fp6_norm_arbiter.sv
// Round-robin arbiter sharing one FP6 normalizer among NUM_REQ adder lanes.
//   clk, rst_n           : clock, synchronous active-low reset
//   req_valid/req_ready  : per-lane handshake (req_ready combinational)
//   req_sign/req_e/req_m : per-lane raw sum
//   out_valid/out_ready  : result handshake
//   out_sign/e/m/id      : normalized result and source lane, from stage-2 flops
module fp6_norm_arbiter
  import fp6_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_sign,
  input  logic [NUM_REQ-1:0][1:0] req_e,
  input  logic [NUM_REQ-1:0][3:0] req_m,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic [1:0]              out_e,
  output logic [4:0]              out_m,
  output logic [ID_W-1:0]         out_id
);

  logic            s1_valid;
  fp6_raw_t        s1_raw;
  logic [ID_W-1:0] s1_id;
  logic            s2_valid;
  fp6_norm_t       s2_res;
  logic [ID_W-1:0] s2_id;
  logic [ID_W-1:0] rr_ptr;

  logic [ID_W-1:0] grant;
  logic            grant_found;
  logic            s1_can_load;
  logic            s2_can_load;
  logic            accept;
  fp6_norm_t       norm_c;
  fp6_norm_t       s2_next;

  // Handshake: stage 2 frees on drain, stage 1 frees when it can move into stage 2.
  assign s2_can_load = !s2_valid || out_ready;
  assign s1_can_load = !s1_valid || s2_can_load;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] idx_t;
    grant       = '0;
    grant_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx   = (32'(rr_ptr) + k) % NUM_REQ;
      idx_t = ID_W'(idx);
      if (!grant_found && req_valid[idx_t]) begin
        grant       = idx_t;
        grant_found = 1'b1;
      end
    end
  end

  // No acceptance while reset is asserted.
  assign accept = rst_n && grant_found && s1_can_load;

  always_comb begin
    req_ready        = '0;
    req_ready[grant] = accept;
  end

  addition_normalizer_fp6 u_norm (
    .raw    (s1_raw),
    .norm_c (norm_c)
  );

  // Zero mantissa bypasses the normalizer, keeping only the sign.
  always_comb begin
    s2_next = norm_c;
    if (s1_raw.m == 4'd0) begin
      s2_next.e = 2'd0;
      s2_next.m = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_raw   <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_id    <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
      end
      if (s1_can_load) begin
        s1_valid <= accept;
        if (accept) begin
          s1_raw <= '{sign: req_sign[grant], e: req_e[grant], m: req_m[grant]};
          s1_id  <= grant;
        end
      end
      if (s2_can_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_res <= s2_next;
          s2_id  <= s1_id;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_sign  = s2_res.sign;
  assign out_e     = s2_res.e;
  assign out_m     = s2_res.m;
  assign out_id    = s2_id;

endmodule

// File: tb/tb_fp6_norm_arbiter.sv
// Directed bench for fp6_norm_arbiter: vector table for the normalizer plus
// hand sequences for reset, fairness, backpressure and mid-flight reset.
module tb_fp6_norm_arbiter;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [3:0]      req_sign;
  logic [3:0][1:0] req_e;
  logic [3:0][3:0] req_m;
  logic            out_valid;
  logic            out_ready;
  logic            out_sign;
  logic [1:0]      out_e;
  logic [4:0]      out_m;
  logic [1:0]      out_id;

  int checks   = 0;
  int failures = 0;
  logic mon_en;

  fp6_norm_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sign  (req_sign),
    .req_e     (req_e),
    .req_m     (req_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_e     (out_e),
    .out_m     (out_m),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Default lane data: mantissa has the hidden bit, so the result passes through.
  task automatic set_defaults();
    for (int i = 0; i < 4; i++) begin
      req_sign[i] = i[0];
      req_e[i]    = 2'(i);
      req_m[i]    = 4'b1000 | 4'(i);
    end
  endtask

  // Scoreboard for passthrough data: enqueue on accept, compare on drain.
  typedef struct packed {
    logic [1:0] id;
    logic       s;
    logic [1:0] e;
    logic [4:0] m;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else if (mon_en) begin
      if (out_valid && out_ready) begin
        check("sb_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_t x;
          x = q.pop_front();
          check("sb_id", 32'(out_id), 32'(x.id));
          check("sb_sign", 32'(out_sign), 32'(x.s));
          check("sb_e", 32'(out_e), 32'(x.e));
          check("sb_m", 32'(out_m), 32'(x.m));
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          q.push_back({2'(i), req_sign[i], req_e[i], {1'b0, req_m[i]}});
        end
      end
    end
  end

  typedef struct {
    int         lane;
    logic       s;
    logic [1:0] e;
    logic [3:0] m;
    logic       xs;
    logic [1:0] xe;
    logic [4:0] xm;
  } vec_t;
  vec_t vecs[11];

  initial begin
    vecs[0]  = '{2, 1'b1, 2'd2, 4'b0011, 1'b1, 2'd0, 5'b01100};
    vecs[1]  = '{0, 1'b0, 2'd3, 4'b0000, 1'b0, 2'd0, 5'b00000};
    vecs[2]  = '{1, 1'b1, 2'd3, 4'b0001, 1'b1, 2'd0, 5'b01000};
    vecs[3]  = '{3, 1'b0, 2'd1, 4'b0001, 1'b0, 2'd0, 5'b00010};
    vecs[4]  = '{0, 1'b0, 2'd0, 4'b0100, 1'b0, 2'd0, 5'b00100};
    vecs[5]  = '{1, 1'b0, 2'd2, 4'b1011, 1'b0, 2'd2, 5'b01011};
    vecs[6]  = '{2, 1'b1, 2'd3, 4'b0110, 1'b1, 2'd2, 5'b01100};
    vecs[7]  = '{3, 1'b0, 2'd0, 4'b0010, 1'b0, 2'd2, 5'b01000};
    vecs[8]  = '{0, 1'b0, 2'd2, 4'b0001, 1'b0, 2'd0, 5'b00100};
    vecs[9]  = '{1, 1'b1, 2'd1, 4'b0000, 1'b1, 2'd0, 5'b00000};
    vecs[10] = '{2, 1'b0, 2'd0, 4'b0001, 1'b0, 2'd0, 5'b00001};

    // Reset with every lane requesting.
    mon_en    = 1'b1;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'b1111;
    set_defaults();
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sign", 32'(out_sign), 32'd0);
    check("rst_out_e", 32'(out_e), 32'd0);
    check("rst_out_m", 32'(out_m), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    rst_n = 1'b1;

    // Fairness: all lanes held valid, one grant per cycle in rotation.
    for (int n = 0; n < 8; n++) begin
      #1;
      check("fair_grant", 32'(req_ready), 32'(4'b0001 << (n % 4)));
      check("fair_out_valid", 32'(out_valid), (n >= 2) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    req_valid = 4'b0000;
    step();
    step();
    step();
    check("fair_drained", 32'(out_valid), 32'd0);
    check("fair_sb_empty", 32'(q.size()), 32'd0);

    // Backpressure: lanes 0 and 1 valid, consumer stalled for 5 cycles.
    out_ready = 1'b0;
    req_valid = 4'b0011;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("bp_req_ready", 32'(req_ready), (n == 0) ? 32'd1 : (n == 1) ? 32'd2 : 32'd0);
      if (n >= 2) begin
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_id", 32'(out_id), 32'd0);
        check("bp_out_m", 32'(out_m), 32'b01000);
      end
      @(posedge clk);
      #1;
    end
    req_valid = 4'b0000;
    out_ready = 1'b1;
    step();
    step();
    step();
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_sb_empty", 32'(q.size()), 32'd0);

    // Normalizer vectors, one isolated operation each.
    mon_en = 1'b0;
    foreach (vecs[v]) begin
      set_defaults();
      req_sign[vecs[v].lane] = vecs[v].s;
      req_e[vecs[v].lane]    = vecs[v].e;
      req_m[vecs[v].lane]    = vecs[v].m;
      req_valid              = 4'(1 << vecs[v].lane);
      #1;
      check("vec_req_ready", 32'(req_ready), 32'(1 << vecs[v].lane));
      @(posedge clk);
      #1;
      req_valid = 4'b0000;
      check("vec_early_valid", 32'(out_valid), 32'd0);
      step();
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_out_sign", 32'(out_sign), 32'(vecs[v].xs));
      check("vec_out_e", 32'(out_e), 32'(vecs[v].xe));
      check("vec_out_m", 32'(out_m), 32'(vecs[v].xm));
      check("vec_out_id", 32'(out_id), 32'(vecs[v].lane));
      step();
    end

    // Mid-flight reset with both stages occupied and rr_ptr away from 0.
    set_defaults();
    mon_en    = 1'b1;
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    check("mf_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("mf_rst_valid", 32'(out_valid), 32'd0);
    check("mf_rr_ptr0", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("mf_s1_discarded", 32'(out_valid), 32'd0);
    check("mf_next_grant", 32'(req_ready), 32'd2);
    req_valid = 4'b0000;
    step();
    check("mf_new_result", 32'(out_valid), 32'd1);
    step();
    step();
    check("mf_drained", 32'(out_valid), 32'd0);
    check("mf_sb_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
